fb_edge_meter: RTL



---
 rtl/fb_edge_meter.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/fb_edge_meter.sv
// fb_edge_meter: feedback-pin conditioner for the PLL front end.
// Synchronizes and deglitches the raw feedback pin, emits a one-cycle
// rising-edge strobe, measures edge-to-edge period in clk_50 cycles and
// flags signal loss (timeout) and over-frequency (period too short).
// Optional build macro FB_AVG_EN: report the average of every 4 valid
// periods instead of each period individually.
// Strobe semantics: period_vld, fb_edge, err_fast and err_slow are
// single-cycle valid pulses with no ready/backpressure; the consumer must
// sample them in the cycle they are high.

module fb_edge_meter #(
    parameter int FILT_LEN   = 4,
    parameter int PER_W      = 16,
    parameter int TIMEOUT    = 500,
    parameter int MIN_PERIOD = 166
) (
    input  logic             clk_50,
    input  logic             rst_n,
    input  logic             fb_u,
    output logic             fb_f,
    output logic             fb_edge,
    output logic [PER_W-1:0] period,
    output logic             period_vld,
    output logic             sig_ok,
    output logic             err_fast,
    output logic             err_slow,
    output logic             state_dbg
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_TRACK = 1'b1
    } state_t;

    localparam logic [3:0]       FILT_LAST = 4'(FILT_LEN - 1);
    localparam logic [PER_W-1:0] PER_MAX   = '1;
    localparam logic [PER_W-1:0] PER_ONE   = PER_W'(1);
    localparam logic [PER_W-1:0] TO_LAST   = PER_W'(TIMEOUT - 1);
    localparam logic [PER_W-1:0] PER_MIN   = PER_W'(MIN_PERIOD);

    state_t           state;
    logic             fb_s0;
    logic             fb_s1;
    logic [3:0]       filt_ctr;
    logic             fb_f_1a;
    logic [PER_W-1:0] per_ctr;
    logic [PER_W-1:0] p_meas;
    logic             rise;
    logic             period_ok;
    logic             timeout_hit;

`ifdef FB_AVG_EN
    logic [PER_W+1:0] acc;
    logic [PER_W+1:0] acc_sum;
    logic [1:0]       avg_ph;
`endif

    // A rise is seen one cycle before fb_edge goes high; FSM outputs are
    // registered on the same edge so they line up with fb_edge.
    assign rise        = fb_f & ~fb_f_1a;
    assign p_meas      = (per_ctr == PER_MAX) ? PER_MAX : per_ctr + PER_ONE;
    assign period_ok   = (p_meas >= PER_MIN);
    assign timeout_hit = (per_ctr == TO_LAST);
    assign state_dbg   = (state == S_TRACK);

`ifdef FB_AVG_EN
    assign acc_sum = acc + {2'b00, p_meas};
`endif

    // Two-flop synchronizer for the asynchronous pin.
    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            fb_s0 <= 1'b0;
            fb_s1 <= 1'b0;
        end else begin
            fb_s0 <= fb_u;
            fb_s1 <= fb_s0;
        end
    end

    // Level filter: accept a new level only after FILT_LEN consecutive clocks.
    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            filt_ctr <= 4'd0;
            fb_f     <= 1'b0;
        end else if (fb_s1 != fb_f) begin
            if (filt_ctr == FILT_LAST) begin
                fb_f     <= ~fb_f;
                filt_ctr <= 4'd0;
            end else begin
                filt_ctr <= filt_ctr + 4'd1;
            end
        end else begin
            filt_ctr <= 4'd0;
        end
    end

    // Registered rising-edge strobe of the filtered level.
    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            fb_f_1a <= 1'b0;
            fb_edge <= 1'b0;
        end else begin
            fb_f_1a <= fb_f;
            fb_edge <= rise;
        end
    end

    // Clocks since the last accepted rise, saturating at all-ones.
    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            per_ctr <= '0;
        end else if (rise) begin
            per_ctr <= '0;
        end else if (per_ctr != PER_MAX) begin
            per_ctr <= per_ctr + PER_ONE;
        end
    end

    // Lock FSM: qualifies each measured period and tracks signal presence.
    // A rise on the timeout clock takes priority over the timeout.
    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            period     <= '0;
            period_vld <= 1'b0;
            sig_ok     <= 1'b0;
            err_fast   <= 1'b0;
            err_slow   <= 1'b0;
`ifdef FB_AVG_EN
            acc        <= '0;
            avg_ph     <= 2'd0;
`endif
        end else begin
            period_vld <= 1'b0;
            err_fast   <= 1'b0;
            err_slow   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rise) begin
                        state <= S_TRACK;
                    end
                end
                S_TRACK: begin
                    if (rise) begin
                        if (period_ok) begin
`ifdef FB_AVG_EN
                            if (avg_ph == 2'd3) begin
                                period     <= acc_sum[PER_W+1:2];
                                period_vld <= 1'b1;
                                sig_ok     <= 1'b1;
                                acc        <= '0;
                                avg_ph     <= 2'd0;
                            end else begin
                                acc    <= acc_sum;
                                avg_ph <= avg_ph + 2'd1;
                            end
`else
                            period     <= p_meas;
                            period_vld <= 1'b1;
                            sig_ok     <= 1'b1;
`endif
                        end else begin
                            err_fast <= 1'b1;
                            sig_ok   <= 1'b0;
`ifdef FB_AVG_EN
                            acc      <= '0;
                            avg_ph   <= 2'd0;
`endif
                        end
                    end else if (timeout_hit) begin
                        err_slow <= 1'b1;
                        sig_ok   <= 1'b0;
                        state    <= S_IDLE;
`ifdef FB_AVG_EN
                        acc      <= '0;
                        avg_ph   <= 2'd0;
`endif
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
